// File: rtl/layer_sequencer.sv
// layer_sequencer: per-layer responder to main_controller. Latches one layer's
// configuration, walks filter groups (outer) and conv-output rows (inner),
// issues one tile per (group,row) to the systolic engine and pulses done_layer
// once the last tile has completed.
module layer_sequencer #(
  parameter int unsigned NUM_PE       = 16,
  parameter int unsigned OFM_RAM_SIZE = 2378675,
  localparam int unsigned ADDR_W      = $clog2(OFM_RAM_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_layer,
  input  logic [8:0]        ifm_size,
  input  logic [10:0]       ifm_channel,
  input  logic [1:0]        kernel_size,
  input  logic [10:0]       num_filter,
  input  logic [ADDR_W-1:0] start_read_addr,
  input  logic [ADDR_W-1:0] start_write_addr,
  output logic              tile_start,
  output logic [6:0]        tile_group,
  output logic [8:0]        tile_row,
  output logic [ADDR_W-1:0] tile_read_addr,
  output logic [ADDR_W-1:0] tile_write_addr,
  input  logic              tile_done,
  output logic              busy,
  output logic              cfg_err,
  output logic              done_layer
);

  localparam int unsigned IFM_W = 9;
  localparam int unsigned NF_W  = 11;
  localparam int unsigned GRP_W = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;

  // Latched layer configuration
  logic [IFM_W-1:0]  cfg_ifm;
  logic [1:0]        cfg_k;
  logic [NF_W-1:0]   cfg_nf;
  logic [ADDR_W-1:0] cfg_rd;
  logic [ADDR_W-1:0] cfg_wr;

  // Derived loop bounds and address strides, captured in LATCH
  logic [IFM_W-1:0]  conv_m1;
  logic [GRP_W-1:0]  ngrp_m1;
  logic [ADDR_W-1:0] row_step;
  logic [ADDR_W-1:0] grp_stride;
  logic [ADDR_W-1:0] grp_base;

  logic              legal_c;
  logic [IFM_W-1:0]  conv_m1_c;
  logic [IFM_W-1:0]  conv_size_c;
  logic [GRP_W-1:0]  ngrp_m1_c;
  logic [ADDR_W-1:0] plane_c;
  logic [ADDR_W-1:0] grp_stride_c;

  // ifm_channel goes straight to the engine; nothing here iterates over it
  logic unused_ifm_channel;
  assign unused_ifm_channel = ^ifm_channel;

  // Legality and derived layer geometry from the latched configuration
  always_comb begin
    legal_c      = ((cfg_k == 2'd1) || (cfg_k == 2'd3)) &&
                   (cfg_ifm >= IFM_W'(cfg_k)) && (cfg_nf != '0);
    conv_m1_c    = cfg_ifm - IFM_W'(cfg_k);
    conv_size_c  = conv_m1_c + IFM_W'(1);
    ngrp_m1_c    = GRP_W'((cfg_nf - NF_W'(1)) / NF_W'(NUM_PE));
    plane_c      = ADDR_W'(conv_size_c) * ADDR_W'(conv_size_c);
    grp_stride_c = ADDR_W'(NUM_PE) * plane_c;
  end

  // Layer FSM with registered tile/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cfg_ifm         <= '0;
      cfg_k           <= '0;
      cfg_nf          <= '0;
      cfg_rd          <= '0;
      cfg_wr          <= '0;
      conv_m1         <= '0;
      ngrp_m1         <= '0;
      row_step        <= '0;
      grp_stride      <= '0;
      grp_base        <= '0;
      tile_start      <= 1'b0;
      tile_group      <= '0;
      tile_row        <= '0;
      tile_read_addr  <= '0;
      tile_write_addr <= '0;
      busy            <= 1'b0;
      cfg_err         <= 1'b0;
      done_layer      <= 1'b0;
    end else begin
      tile_start <= 1'b0;
      done_layer <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_layer) begin
            cfg_ifm <= ifm_size;
            cfg_k   <= kernel_size;
            cfg_nf  <= num_filter;
            cfg_rd  <= start_read_addr;
            cfg_wr  <= start_write_addr;
            cfg_err <= 1'b0;
            busy    <= 1'b1;
            state   <= S_LATCH;
          end
        end
        S_LATCH: begin
          tile_group <= '0;
          tile_row   <= '0;
          conv_m1    <= conv_m1_c;
          ngrp_m1    <= ngrp_m1_c;
          row_step   <= ADDR_W'(conv_size_c);
          grp_stride <= grp_stride_c;
          grp_base   <= cfg_wr;
          if (!legal_c) begin
            cfg_err    <= 1'b1;
            done_layer <= 1'b1;
            state      <= S_DONE;
          end else begin
            tile_read_addr  <= cfg_rd;
            tile_write_addr <= cfg_wr;
            tile_start      <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tile_done) begin
            if (tile_row != conv_m1) begin
              tile_row        <= tile_row + IFM_W'(1);
              tile_read_addr  <= tile_read_addr + ADDR_W'(cfg_ifm);
              tile_write_addr <= tile_write_addr + row_step;
              tile_start      <= 1'b1;
              state           <= S_ISSUE;
            end else if (tile_group != ngrp_m1) begin
              tile_row        <= '0;
              tile_group      <= tile_group + GRP_W'(1);
              tile_read_addr  <= cfg_rd;
              grp_base        <= grp_base + grp_stride;
              tile_write_addr <= grp_base + grp_stride;
              tile_start      <= 1'b1;
              state           <= S_ISSUE;
            end else begin
              done_layer <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized engine responder with a tile-list reference model.
module tb_layer_sequencer;

  localparam int unsigned AW     = 22;
  localparam int          NUM_PE = 16;

  typedef struct {
    int          g;
    int          r;
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
  } tile_t;

  logic          clk;
  logic          rst_n;
  logic          start_layer;
  logic [8:0]    ifm_size;
  logic [10:0]   ifm_channel;
  logic [1:0]    kernel_size;
  logic [10:0]   num_filter;
  logic [AW-1:0] start_read_addr;
  logic [AW-1:0] start_write_addr;
  logic          tile_start;
  logic [6:0]    tile_group;
  logic [8:0]    tile_row;
  logic [AW-1:0] tile_read_addr;
  logic [AW-1:0] tile_write_addr;
  logic          tile_done;
  logic          busy;
  logic          cfg_err;
  logic          done_layer;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  layer_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_layer      (start_layer),
    .ifm_size         (ifm_size),
    .ifm_channel      (ifm_channel),
    .kernel_size      (kernel_size),
    .num_filter       (num_filter),
    .start_read_addr  (start_read_addr),
    .start_write_addr (start_write_addr),
    .tile_start       (tile_start),
    .tile_group       (tile_group),
    .tile_row         (tile_row),
    .tile_read_addr   (tile_read_addr),
    .tile_write_addr  (tile_write_addr),
    .tile_done        (tile_done),
    .busy             (busy),
    .cfg_err          (cfg_err),
    .done_layer       (done_layer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {tile_start, tile_group, tile_row, tile_read_addr, tile_write_addr,
            busy, cfg_err, done_layer};
  endfunction

  task automatic idle_cycles(input int n, input bit exp_err);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("done_fall", done_layer, 1'b0);
      check("busy_idle", busy, 1'b0);
      check("no_tile_idle", tile_start, 1'b0);
      check("cfg_err_sticky", cfg_err, exp_err);
    end
  endtask

  // Drives one layer from the current negedge; models the expected tile list
  // directly from the layer geometry and answers each tile after a random delay.
  task automatic run_layer(input int ifm, input int k, input int nf,
                           input logic [AW-1:0] rd, input logic [AW-1:0] wr,
                           input bit stray, input int rst_tile, output bit err_out);
    tile_t  q[$];
    bit     legal;
    int     conv;
    int     ng;
    longint plane;
    int     exp_cyc;
    int     idx;
    int     cnt;
    bit     in_wait;
    bit     fin;
    legal = ((k == 1) || (k == 3)) && (ifm >= k) && (nf != 0);
    if (legal) begin
      conv  = ifm - k + 1;
      ng    = (nf + NUM_PE - 1) / NUM_PE;
      plane = longint'(conv) * conv;
      for (int g = 0; g < ng; g++)
        for (int r = 0; r < conv; r++)
          q.push_back('{g, r, AW'(longint'(rd) + longint'(r) * ifm),
                       AW'(longint'(wr) + longint'(g) * NUM_PE * plane + longint'(r) * conv)});
    end
    err_out          = !legal;
    ifm_size         = 9'(ifm);
    kernel_size      = 2'(k);
    num_filter       = 11'(nf);
    start_read_addr  = rd;
    start_write_addr = wr;
    ifm_channel      = 11'($urandom);
    start_layer      = 1'b1;
    exp_cyc          = cyc + 2;
    idx              = 0;
    cnt              = 0;
    in_wait          = 1'b0;
    fin              = 1'b0;
    for (int it = 0; it < 4000 && !fin; it++) begin
      @(negedge clk);
      start_layer = 1'b0;
      tile_done   = 1'b0;
      if (it == 0) begin
        check("busy_rise", busy, 1'b1);
        check("cfg_err_clear", cfg_err, 1'b0);
      end
      if (tile_start) begin
        check("tile_latency", cyc, exp_cyc);
        if (idx < q.size()) begin
          check("tile_group", tile_group, q[idx].g);
          check("tile_row", tile_row, q[idx].r);
          check("tile_read_addr", tile_read_addr, q[idx].rd);
          check("tile_write_addr", tile_write_addr, q[idx].wr);
        end else begin
          check("extra_tile", idx, q.size());
        end
        idx++;
        in_wait = 1'b1;
        cnt     = $urandom_range(1, 4);
        if (stray) tile_done = 1'b1;
      end else if (done_layer) begin
        check("done_latency", cyc, exp_cyc);
        check("tile_count", idx, q.size());
        check("cfg_err", cfg_err, !legal);
        check("busy_at_done", busy, 1'b1);
        fin = 1'b1;
      end else if (in_wait) begin
        check("busy_wait", busy, 1'b1);
        if (idx <= q.size())
          check("tile_hold", {tile_group, tile_row, tile_read_addr, tile_write_addr},
                {7'(q[idx-1].g), 9'(q[idx-1].r), q[idx-1].rd, q[idx-1].wr});
        if (rst_tile > 0 && idx == rst_tile) begin
          rst_n = 1'b0;
          #1;
          check("async_reset_outs", all_outs(), 64'd0);
          @(negedge clk);
          check("reset_held_outs", all_outs(), 64'd0);
          rst_n   = 1'b1;
          err_out = 1'b0;
          return;
        end
        cnt--;
        if (cnt == 0) begin
          tile_done = 1'b1;
          exp_cyc   = cyc + 1;
          in_wait   = 1'b0;
        end else if (stray && ($urandom_range(0, 1) == 1)) begin
          start_layer      = 1'b1;
          ifm_size         = 9'($urandom);
          kernel_size      = 2'($urandom);
          num_filter       = 11'($urandom);
          start_read_addr  = AW'($urandom);
          start_write_addr = AW'($urandom);
        end
      end
    end
    if (!fin) check("layer_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    bit e;
    rst_n            = 1'b0;
    start_layer      = 1'b0;
    tile_done        = 1'b0;
    ifm_size         = '0;
    ifm_channel      = '0;
    kernel_size      = '0;
    num_filter       = '0;
    start_read_addr  = '0;
    start_write_addr = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    idle_cycles(2, 1'b0);

    // Reference layer from the block's bring-up list
    run_layer(8, 3, 16, 22'd100, 22'd1000, 1'b0, 0, e);
    idle_cycles(1, e);
    // Three filter groups
    run_layer(4, 1, 40, AW'($urandom), AW'($urandom), 1'b0, 0, e);
    idle_cycles(1, e);
    // Illegal configurations
    run_layer(5, 2, 8, 22'd7, 22'd9, 1'b0, 0, e);
    idle_cycles(1, e);
    run_layer(2, 3, 8, 22'd7, 22'd9, 1'b0, 0, e);
    idle_cycles(2, e);
    run_layer(4, 1, 0, 22'd7, 22'd9, 1'b0, 0, e);
    idle_cycles(1, e);
    // Stray start_layer / tile_done pulses
    run_layer(6, 3, 20, AW'($urandom), AW'($urandom), 1'b1, 0, e);
    idle_cycles(1, e);
    // Reset in WAIT of the third tile, then a fresh layer
    run_layer(6, 1, 16, 22'd50, 22'd500, 1'b0, 3, e);
    idle_cycles(1, 1'b0);
    run_layer(6, 1, 16, 22'd50, 22'd500, 1'b0, 0, e);
    idle_cycles(1, e);
    // Single-tile layer, then address wrap near the top of the space
    run_layer(3, 3, 5, 22'h3FFFF0, 22'h3FFFF8, 1'b0, 0, e);
    idle_cycles(1, e);
    run_layer(9, 1, 33, 22'h3FFFF0, 22'h3FF000, 1'b0, 0, e);
    idle_cycles(1, e);

    for (int n = 0; n < 10; n++) begin
      run_layer($urandom_range(1, 10), $urandom_range(0, 3), $urandom_range(0, 50),
                AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)), 0, e);
      idle_cycles($urandom_range(1, 3), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
